// File: rtl/downsample2d_stream.sv
// Streaming SCALE x SCALE average-pool downsampler over channel-major raster pixels.
// One row of partial window sums is kept; each window's first pixel overwrites its slot.
module downsample2d_stream #(
  parameter int CH        = 1,
  parameter int IN_H      = 4,
  parameter int IN_W      = 4,
  parameter int SCALE     = 2,
  parameter int WIDTH     = 16,
  parameter     precision = "Q8.8"
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             frame_err
);

  localparam int OUT_H = IN_H / SCALE;
  localparam int OUT_W = IN_W / SCALE;
  localparam int LOG2S = $clog2(SCALE);
  localparam int SH    = 2 * LOG2S;
  localparam int ACC_W = WIDTH + SH;
  localparam int CW    = (CH > 1) ? $clog2(CH) : 1;
  localparam int HW    = $clog2(IN_H);
  localparam int WW    = $clog2(IN_W);
  localparam int OWW   = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  localparam logic [CW-1:0]    C_MAX   = CW'(CH - 1);
  localparam logic [HW-1:0]    H_MAX   = HW'(IN_H - 1);
  localparam logic [WW-1:0]    W_MAX   = WW'(IN_W - 1);
  localparam logic [LOG2S-1:0] SUB_MAX = '1;

  // Elaboration-time guard against geometries the pooling arithmetic cannot handle.
  if (SCALE < 2 || (SCALE & (SCALE - 1)) != 0 || OUT_H * SCALE != IN_H ||
      OUT_W * SCALE != IN_W || $bits(precision) == 0) begin : g_param_err
    $error("downsample2d_stream: illegal parameter combination");
  end

  logic [CW-1:0]           c;
  logic [HW-1:0]           h;
  logic [WW-1:0]           w;
  logic signed [ACC_W-1:0] acc [OUT_W];

  logic                    accept;
  logic                    at_frame_end;
  logic                    win_first;
  logic                    win_done;
  logic [OWW-1:0]          ow;
  logic signed [ACC_W-1:0] din_ext;
  logic signed [ACC_W-1:0] sum;
  logic [WIDTH-1:0]        avg;

  assign in_ready = !out_valid || out_ready;

  always_comb begin
    accept       = rst_n && in_valid && in_ready;
    at_frame_end = (c == C_MAX) && (h == H_MAX) && (w == W_MAX);
    win_first    = (h[LOG2S-1:0] == '0) && (w[LOG2S-1:0] == '0);
    win_done     = (h[LOG2S-1:0] == SUB_MAX) && (w[LOG2S-1:0] == SUB_MAX);
    ow           = OWW'(w >> LOG2S);
    din_ext      = ACC_W'(signed'(in_data));
    sum          = acc[ow] + din_ext;
    // Arithmetic shift floors toward minus infinity; the quotient always fits WIDTH.
    avg          = WIDTH'(sum >>> SH);
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      acc[ow] <= win_first ? din_ext : sum;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c <= '0;
      h <= '0;
      w <= '0;
    end else if (accept) begin
      if (w == W_MAX) begin
        w <= '0;
        if (h == H_MAX) begin
          h <= '0;
          c <= (c == C_MAX) ? '0 : c + CW'(1);
        end else begin
          h <= h + HW'(1);
        end
      end else begin
        w <= w + WW'(1);
      end
    end
  end

  // A completing beat can only be accepted when the register is empty or draining.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (accept && win_done) begin
      out_valid <= 1'b1;
      out_data  <= avg;
      out_last  <= at_frame_end;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
    end else if (accept && (in_last != at_frame_end)) begin
      frame_err <= 1'b1;
    end
  end

endmodule

// File: doc/downsample2d_stream.md
Name: downsample2d_stream

Overview:
- Streaming SCALE x SCALE average-pool downsampler. It is the inverse of the packed nearest-neighbour upsampler: averaging a block and then upsampling it reproduces constant blocks exactly.
- Consumes one fixed-point pixel per handshake in channel-major raster order, so pixel index = (ch*IN_H + h)*IN_W + w, the same ordering as the packed feature-map vectors.
- Emits one averaged pixel per SCALE x SCALE window, in the same ordering over (ch, OUT_H, OUT_W).
- Sits between streaming conv/activation stages and a downstream valid/ready consumer.

Parameters:
- CH, 1: channels per frame.
- IN_H, 4: input height. Must be a multiple of SCALE.
- IN_W, 4: input width. Must be a multiple of SCALE.
- SCALE, 2: pooling factor. Must be a power of 2 and >= 2.
- WIDTH, 16: signed pixel width.
- precision, "Q8.8": fixed-point format tag. Informational only; averaging is format-independent.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept an input beat.
- in_data  in  WIDTH  signed input pixel.
- in_last  in  1  asserted with the final pixel of a frame.
- out_valid  out  1  output pixel valid.
- out_ready  in  1  downstream accepts the output pixel.
- out_data  out  WIDTH  signed averaged pixel.
- out_last  out  1  asserted with the final output pixel of a frame.
- frame_err  out  1  sticky in_last/position mismatch flag.

Behaviour:
- Derived constants:
  - OUT_H = IN_H/SCALE, OUT_W = IN_W/SCALE.
  - SH = 2*log2(SCALE).
  - ACC_W = WIDTH + SH.
- Handshakes:
  - Input accepted when in_valid && in_ready.
  - Output transfers when out_valid && out_ready.
  - in_ready = !out_valid || out_ready (combinational). No other backpressure source.
- State:
  - Position counters c, h, w track the accepted input beat.
  - Row accumulator array acc[0..OUT_W-1], each ACC_W bits signed. Slot ow = w/SCALE.
- On each accepted beat:
  - First pixel of a window (h%SCALE==0 && w%SCALE==0): acc[ow] <= sign-extended in_data. This overwrites stale contents, so no clear cycle is needed.
  - Intermediate pixel: acc[ow] <= acc[ow] + in_data.
  - Window-completing pixel (h%SCALE==SCALE-1 && w%SCALE==SCALE-1):
    - sum = acc[ow] + in_data.
    - out_data <= sum >>> SH (arithmetic shift, floor rounding), truncated to WIDTH bits.
    - out_valid <= 1.
    - out_last <= (c==CH-1 && h==IN_H-1 && w==IN_W-1).
- Latency: out_valid rises on the clock edge that accepts the window-completing pixel, i.e. visible the cycle after that beat.
- Output register: out_data and out_last hold stable while out_valid && !out_ready. On a transfer with no new completion in the same cycle, out_valid <= 0. A simultaneous transfer and new completion reloads the register with no bubble.
- Counter advance: w increments. On w==IN_W-1, w wraps to 0 and h increments. On h==IN_H-1, h wraps and c increments. On c==CH-1, c wraps to 0 (next frame). A frame has CH*IN_H*IN_W input beats and CH*OUT_H*OUT_W output beats.
- frame_err:
  - Set on any accepted beat where in_last != (c==CH-1 && h==IN_H-1 && w==IN_W-1).
  - Sticky until reset.
  - Counters do not resync on in_last; data processing is unaffected.
- Reset (rst_n==0 at clk edge), any time including mid-frame:
  - c=h=w=0, out_valid=0, out_data=0, out_last=0, frame_err=0.
  - Partial window sums are discarded; acc contents need no reset.
  - in_ready reads 1 while in reset, but no beat is accepted during reset.
- Overflow: the intermediate sum cannot overflow ACC_W. The average always fits WIDTH bits.

Test Plan:
1. CH=1, IN 4x4, SCALE=2; 16 beats of 0x0100 with out_ready=1 -> 4 outputs of 0x0100, each 1 cycle after beats 6, 8, 14, 16 (1-based). out_last only on the 4th output. frame_err=0.
2. Window (0,0),(0,1),(1,0),(1,1) = 0x0100, 0x0200, 0x0300, 0x0400 -> first output 0x0280 (2.5 in Q8.8).
3. Window of 0xFFFF x3 plus 0x0000 (sum -3) -> output 0xFFFF (floor of -0.75). Window of 0x7FFF x4 -> 0x7FFF, no wrap.
4. Hold out_ready=0 when the first output is pending -> in_ready=0, out_data/out_last stable over 5 cycles. Raise out_ready with an in_valid completion beat in the same cycle -> back-to-back outputs, no dropped or duplicated pixel.
5. Assert rst_n=0 for 1 cycle after 5 accepted beats, then send a full all-0x0200 frame -> exactly 4 outputs of 0x0200, no stale partials, out_last on the 4th.
6. CH=2, 4x4: ch0 all 0x0100, ch1 all 0x0300 -> 4 outputs 0x0100 then 4 outputs 0x0300, out_last only on output 8. In a separate run, in_last asserted on beat 7 -> frame_err=1 and held through the next frame, while outputs stay correct.
